// File: rtl/half_pkg.sv
// Shared half-precision types and constants for the vector packer and the
// min/max/sum reducers that consume its output.
package half_pkg;

  typedef logic [15:0] half_t;

  localparam half_t HALF_ZERO    = 16'h0000;
  localparam half_t HALF_POS_INF = 16'h7C00;
  localparam half_t HALF_NEG_INF = 16'hFC00;

endpackage

// File: rtl/half_vector_pack_if.sv
// Element stream in, assembled vector out. The packer sits on the slave side.
interface half_vector_pack_if
  import half_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) ();

  logic          in_valid;
  logic          in_ready;
  half_t         in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  half_t         vector_c [WIDTH];
  logic [CW-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, vector_c, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, vector_c, out_count
  );

endinterface

// File: rtl/half_vector_bank.sv
// One vector buffer: writes an element at idx and, when the vector closes,
// replicates that element into every higher lane and latches the real count.
module half_vector_bank
  import half_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          complete,
  input  logic [CW-1:0] idx,
  input  half_t         data,
  output half_t         lanes [WIDTH],
  output logic [CW-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < WIDTH; j++) lanes[j] <= HALF_ZERO;
      count <= '0;
    end else if (wr_en) begin
      // Lanes above idx take the closing element so a min/max is unaffected.
      for (int j = 0; j < WIDTH; j++) begin
        if (j == int'(idx) || (complete && j > int'(idx))) lanes[j] <= data;
      end
      if (complete) count <= idx + CW'(1);
    end
  end

endmodule

// File: rtl/half_vector_pack.sv
// Serial-to-vector packer with ping-pong banks: one bank fills while the
// other is held for the downstream reducer.
module half_vector_pack
  import half_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  half_vector_pack_if.slave  bus
);

  logic [CW-1:0] cnt;
  logic          wr_sel;
  logic          rd_sel;
  logic [1:0]    full;

  logic          in_ready_i;
  logic          out_valid_i;
  logic          accept;
  logic          complete;
  logic          xfer;
  logic [1:0]    wr_en;

  half_t         lanes0 [WIDTH];
  half_t         lanes1 [WIDTH];
  logic [CW-1:0] count0;
  logic [CW-1:0] count1;

  assign in_ready_i  = !full[wr_sel];
  assign out_valid_i = full[rd_sel];
  assign accept      = bus.in_valid && in_ready_i;
  assign complete    = accept && (bus.in_last || cnt == CW'(WIDTH - 1));
  assign xfer        = out_valid_i && bus.out_ready;
  assign wr_en       = {accept && wr_sel, accept && !wr_sel};

  // A completing write and a release always target different banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      full   <= 2'b00;
    end else begin
      if (accept) cnt <= complete ? '0 : cnt + CW'(1);
      if (complete) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
      if (xfer) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
    end
  end

  half_vector_bank #(.WIDTH(WIDTH), .CW(CW)) u_bank0 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en[0]),
    .complete (complete),
    .idx      (cnt),
    .data     (bus.in_data),
    .lanes    (lanes0),
    .count    (count0)
  );

  half_vector_bank #(.WIDTH(WIDTH), .CW(CW)) u_bank1 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en[1]),
    .complete (complete),
    .idx      (cnt),
    .data     (bus.in_data),
    .lanes    (lanes1),
    .count    (count1)
  );

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = out_valid_i;
  assign bus.out_count = rd_sel ? count1 : count0;

  always_comb begin
    for (int j = 0; j < WIDTH; j++) bus.vector_c[j] = rd_sel ? lanes1[j] : lanes0[j];
  end

endmodule

// File: tb/tb_half_vector_pack.sv
// Bench for half_vector_pack: a queue model checks the WIDTH=16 instance every
// cycle; a WIDTH=5 instance is checked per transfer against a min scoreboard.
module tb_half_vector_pack;
  import half_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  half_vector_pack_if #(.WIDTH(16)) bus16 ();
  half_vector_pack_if #(.WIDTH(5))  bus5 ();

  half_vector_pack #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  half_vector_pack #(.WIDTH(5))  dut5  (.clk(clk), .rst(rst), .bus(bus5.slave));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] hkey(half_t h);
    return h[15] ? ~h : (h | 16'h8000);
  endfunction

  function automatic half_t hmin(half_t a, half_t b);
    return (hkey(a) <= hkey(b)) ? a : b;
  endfunction

  function automatic half_t rand_half();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom_range(0, 1023))};
  endfunction

  // Model of the WIDTH=16 instance: held vectors are a FIFO of at most two.
  typedef half_t vec16_t [16];
  vec16_t mq[$];
  int     mc[$];
  vec16_t cur;
  int     cur_n = 0;
  bit     m_on  = 0;
  int     out_cyc[$];
  int     xf16  = 0;
  int     cap_n = 0;
  half_t  cap_lane0;
  int     cap_count;
  int     stalls16 = 0;

  always @(negedge clk) begin
    bit acc, xf;
    int bad;
    if (m_on) begin
      check("in_ready16", bus16.in_ready, mq.size() < 2);
      check("out_valid16", bus16.out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("out_count16", bus16.out_count, mc[0]);
        bad = -1;
        for (int j = 0; j < 16; j++) if (bus16.vector_c[j] !== mq[0][j] && bad < 0) bad = j;
        tests++;
        if (bad >= 0) begin
          fails++;
          $display("FAIL vector16 lane %0d: got %h expected %h (cycle %0d)",
                   bad, bus16.vector_c[bad], mq[0][bad], cyc);
        end
      end
      if (bus16.out_valid === 1'b1) out_cyc.push_back(cyc);
      if (bus16.out_valid === 1'b1 && bus16.out_ready === 1'b1) begin
        if (cap_n == 0) begin
          cap_lane0 = bus16.vector_c[0];
          cap_count = int'(bus16.out_count);
        end
        cap_n++;
        xf16++;
      end
    end
    if (rst) begin
      mq.delete();
      mc.delete();
      cur_n = 0;
      m_on  = 1;
    end else if (m_on) begin
      acc = bus16.in_valid && (mq.size() < 2);
      xf  = bus16.out_ready && (mq.size() > 0);
      if (xf) begin
        void'(mq.pop_front());
        void'(mc.pop_front());
      end
      if (acc) begin
        cur[cur_n] = bus16.in_data;
        if (bus16.in_last || cur_n == 15) begin
          for (int j = cur_n + 1; j < 16; j++) cur[j] = bus16.in_data;
          mq.push_back(cur);
          mc.push_back(cur_n + 1);
          cur_n = 0;
        end else begin
          cur_n++;
        end
      end
    end
  end

  // WIDTH=5 scoreboard: expected padded lanes, real count, min of real elements.
  typedef half_t vec5_t [5];
  vec5_t sq[$];
  int    sn[$];
  half_t smin[$];
  bit    t5_rand = 0;

  always @(posedge clk) begin
    #1;
    bus5.out_ready = t5_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    half_t m;
    int bad;
    if (bus5.out_valid === 1'b1 && bus5.out_ready === 1'b1) begin
      check("vec5_expected", sq.size() > 0, 1);
      if (sq.size() > 0) begin
        check("out_count5", bus5.out_count, sn[0]);
        bad = -1;
        m = bus5.vector_c[0];
        for (int j = 0; j < 5; j++) begin
          if (bus5.vector_c[j] !== sq[0][j] && bad < 0) bad = j;
          m = hmin(m, bus5.vector_c[j]);
        end
        tests++;
        if (bad >= 0) begin
          fails++;
          $display("FAIL vector5 lane %0d: got %h expected %h", bad, bus5.vector_c[bad], sq[0][bad]);
        end
        check("min5", m, smin[0]);
        void'(sq.pop_front());
        void'(sn.pop_front());
        void'(smin.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus16.in_valid = 1'b0;
    bus5.in_valid  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send16(input half_t d, input logic last);
    logic rdy;
    bit ok;
    bus16.in_valid = 1'b1;
    bus16.in_data  = d;
    bus16.in_last  = last;
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      rdy = bus16.in_ready;
      if (rdy !== 1'b1) stalls16++;
      @(posedge clk);
      #1;
      ok = (rdy === 1'b1);
    end
    bus16.in_valid = 1'b0;
    bus16.in_last  = 1'b0;
    check("send16_accept", ok, 1);
  endtask

  task automatic send5(input half_t d, input logic last);
    logic rdy;
    bit ok;
    bus5.in_valid = 1'b1;
    bus5.in_data  = d;
    bus5.in_last  = last;
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      rdy = bus5.in_ready;
      @(posedge clk);
      #1;
      ok = (rdy === 1'b1);
    end
    bus5.in_valid = 1'b0;
    bus5.in_last  = 1'b0;
    check("send5_accept", ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    half_t d [5];
    vec5_t e;
    half_t mn;
    int    len, base;
    bit    lst;

    bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.in_last = 1'b0; bus16.out_ready = 1'b1;
    bus5.in_valid  = 1'b0; bus5.in_data  = '0; bus5.in_last  = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", bus16.in_ready, 1);
    check("rst_out_valid", bus16.out_valid, 0);
    check("rst_out_count", bus16.out_count, 0);
    for (int j = 0; j < 16; j++) check("rst_lane", bus16.vector_c[j], 16'h0000);

    // Full vector
    for (int k = 0; k < 16; k++) begin
      send16(16'h3C00 + 16'(k), k == 15);
      if (k == 14) check("full_not_yet_valid", bus16.out_valid, 0);
    end
    check("full_valid", bus16.out_valid, 1);
    check("full_count", bus16.out_count, 16);
    check("full_lane0", bus16.vector_c[0], 16'h3C00);
    check("full_lane7", bus16.vector_c[7], 16'h3C07);
    check("full_lane15", bus16.vector_c[15], 16'h3C0F);
    idle(2);

    // Short vector padded with its last element
    send16(16'h4000, 0); send16(16'h4200, 0); send16(16'h4400, 0);
    send16(16'h4500, 0); send16(16'h4600, 1);
    check("short_valid", bus16.out_valid, 1);
    check("short_count", bus16.out_count, 5);
    check("short_lane2", bus16.vector_c[2], 16'h4400);
    check("short_lane4", bus16.vector_c[4], 16'h4600);
    check("short_lane5", bus16.vector_c[5], 16'h4600);
    check("short_lane15", bus16.vector_c[15], 16'h4600);
    idle(2);

    // Backpressure: two banks fill, input stalls, nothing is lost
    bus16.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) send16(16'h1000 + 16'(i), 0);
    bus16.in_valid = 1'b1;
    bus16.in_data  = 16'h1020;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_in_ready", bus16.in_ready, 0);
      check("bp_lane0", bus16.vector_c[0], 16'h1000);
      check("bp_lane15", bus16.vector_c[15], 16'h100F);
      check("bp_count", bus16.out_count, 16);
      @(posedge clk);
      #1;
    end
    base = xf16;
    bus16.out_ready = 1'b1;
    for (int i = 32; i < 40; i++) send16(16'h1000 + 16'(i), 0);
    idle(4);
    check("bp_vectors_out", xf16 - base, 2);
    do_reset();

    // Back-to-back streaming
    out_cyc.delete();
    stalls16 = 0;
    for (int i = 0; i < 64; i++) send16(16'h2000 + 16'(i), 0);
    idle(3);
    check("b2b_stalls", stalls16, 0);
    check("b2b_vectors", out_cyc.size(), 4);
    for (int i = 1; i < out_cyc.size(); i++) check("b2b_spacing", out_cyc[i] - out_cyc[i-1], 16);

    // Reset mid-vector discards the partial
    for (int i = 0; i < 7; i++) send16(16'h5000 + 16'(i), 0);
    cap_n = 0;
    out_cyc.delete();
    do_reset();
    for (int k = 0; k < 16; k++) send16(16'h6000 + 16'(k), k == 15);
    idle(3);
    check("rst_mid_vectors", cap_n, 1);
    check("rst_mid_pulses", out_cyc.size(), 1);
    check("rst_mid_lane0", cap_lane0, 16'h6000);
    check("rst_mid_count", cap_count, 16);

    // WIDTH=5: directed short vector, then random vectors through the min check
    sq.push_back('{16'h4400, 16'hC000, 16'h3C00, 16'h3C00, 16'h3C00});
    sn.push_back(3);
    smin.push_back(16'hC000);
    send5(16'h4400, 0); send5(16'hC000, 0); send5(16'h3C00, 1);
    check("w5_valid", bus5.out_valid, 1);
    check("w5_count", bus5.out_count, 3);
    check("w5_lane1", bus5.vector_c[1], 16'hC000);
    check("w5_lane4", bus5.vector_c[4], 16'h3C00);
    idle(2);

    t5_rand = 1;
    for (int v = 0; v < 200; v++) begin
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) d[j] = rand_half();
      mn = d[0];
      for (int j = 0; j < 5; j++) begin
        e[j] = (j < len) ? d[j] : d[len-1];
        if (j < len) mn = hmin(mn, d[j]);
      end
      sq.push_back(e);
      sn.push_back(len);
      smin.push_back(mn);
      lst = (len < 5) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++) send5(d[j], (j == len - 1) && lst);
    end
    for (int t = 0; t < 500 && sq.size() > 0; t++) @(posedge clk);
    #1;
    check("w5_drained", sq.size(), 0);
    t5_rand = 0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
